// File: rtl/instruction_fetch.sv
// Fetch stage in front of a 1-cycle-latency instruction ROM. A 2-entry output
// buffer hides the read latency so the decoder can take one instruction per cycle.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_q;
  logic [1:0]            count_q, count_d;
  entry_t                head_q, head_d, tail_q, tail_d;

  logic       pop, issue, wr;
  logic [2:0] occ;
  entry_t     rsp;

  // Out-of-range targets also fold back to 0 on increment.
  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a >= ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_q.instr;
  assign out_pc    = head_q.pc;
  assign pop       = out_valid & out_ready;

  // Occupancy after this cycle's pop; issuing keeps buffered + in-flight <= 2.
  assign occ      = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue    = rst_n & fetch_en & (redirect_valid | (occ <= 3'd1));
  assign rom_en   = issue;
  assign rom_addr = redirect_valid ? redirect_pc : pc_q;

  // A response landing during a redirect belongs to the old stream.
  assign wr  = inflight_q & ~redirect_valid;
  assign rsp = '{pc: inflight_pc_q, instr: rom_dout};

  always_comb begin
    pc_d    = issue ? pc_inc(rom_addr) : (redirect_valid ? redirect_pc : pc_q);
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      case ({wr, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = rsp;
          else                 tail_d = rsp;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = rsp;
          end else begin
            head_d = tail_q;
            tail_d = rsp;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= ADDR_WIDTH'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= rom_addr;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, scored
// against an in-order PC stream model and an outstanding-read counter.
module tb_instruction_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst_n, fetch_en, redirect_valid, out_ready;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] rom_addr, out_pc;
  logic          rom_en, out_valid;
  logic [DW-1:0] rom_dout = '0;
  logic [DW-1:0] out_instr;

  int tests = 0;
  int fails = 0;

  // Model state: next pc the decoder should see, next pc the ROM should see,
  // reads issued but not yet consumed or flushed, and a hold-stability snapshot.
  logic [AW-1:0] exp_pc, fpc, hold_pc;
  logic [DW-1:0] hold_instr;
  int            occ;
  bit            hold_v;

  logic          s_valid, s_en;
  logic [AW-1:0] s_pc, s_addr, p;
  logic [DW-1:0] s_instr;

  instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_dout(rom_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'h1000 + a;
  endfunction

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return (a >= AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  always @(posedge clk) if (rom_en) rom_dout <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample and score at the falling edge, return just after the rising edge.
  task automatic cyc();
    logic [AW-1:0] a;
    @(negedge clk);
    s_valid = out_valid; s_pc = out_pc; s_instr = out_instr;
    s_en = rom_en; s_addr = rom_addr;
    if (!rst_n) begin
      chk("rom_en_in_reset", 64'(rom_en), 64'(0));
      exp_pc = '0; fpc = '0; occ = 0; hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_pc", 64'(out_pc), 64'(hold_pc));
        chk("hold_instr", 64'(out_instr), 64'(hold_instr));
      end
      if (out_valid && out_ready) begin
        chk("pop_pc", 64'(out_pc), 64'(exp_pc));
        chk("pop_instr", 64'(out_instr), 64'(rom_word(exp_pc)));
        exp_pc = nxt(exp_pc);
      end
      if (!fetch_en) chk("no_issue_when_disabled", 64'(rom_en), 64'(0));
      if (redirect_valid) chk("redirect_reissue", 64'(rom_en), 64'(fetch_en));
      if (rom_en) begin
        a = redirect_valid ? redirect_pc : fpc;
        chk("rom_addr", 64'(rom_addr), 64'(a));
        fpc = nxt(a);
      end else if (redirect_valid) begin
        fpc = redirect_pc;
      end
      occ = occ + int'(rom_en) - int'(out_valid && out_ready);
      if (redirect_valid) begin
        occ = int'(rom_en);
        exp_pc = redirect_pc;
      end
      chk("occupancy_le_2", 64'(occ <= 2), 64'(1));
      hold_v = out_valid && !out_ready && !redirect_valid;
      hold_pc = out_pc; hold_instr = out_instr;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    exp_pc = '0; fpc = '0; occ = 0; hold_v = 0;
    run(2);

    // Reset release, first fetch and 2-cycle latency
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    cyc();
    chk("c0_rom_en", 64'(s_en), 64'(1));
    chk("c0_rom_addr", 64'(s_addr), 64'(0));
    chk("c0_reset_valid", 64'(s_valid), 64'(0));
    chk("c0_reset_pc", 64'(s_pc), 64'(0));
    chk("c0_reset_instr", 64'(s_instr), 64'(0));
    cyc();
    chk("c1_valid", 64'(s_valid), 64'(0));
    cyc();
    chk("c2_valid", 64'(s_valid), 64'(1));
    chk("c2_pc", 64'(s_pc), 64'(0));
    chk("c2_instr", 64'(s_instr), 64'(32'h1000));
    cyc();
    chk("c3_pc", 64'(s_pc), 64'(1));

    // Backpressure cycles 4..9
    out_ready = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      cyc();
      chk("bp_rom_en", 64'(s_en), 64'(0));
      chk("bp_valid", 64'(s_valid), 64'(1));
      chk("bp_pc", 64'(s_pc), 64'(2));
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_resume_en", 64'(s_en), 64'(1));
    chk("bp_resume_addr", 64'(s_addr), 64'(4));
    run(5);

    // Redirect with a full buffer
    out_ready = 1'b0;
    run(4);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    cyc();
    chk("rd_en", 64'(s_en), 64'(1));
    chk("rd_addr", 64'(s_addr), 64'(32'h40));
    redirect_valid = 1'b0;
    cyc();
    chk("rd_t1_valid", 64'(s_valid), 64'(0));
    cyc();
    chk("rd_t2_valid", 64'(s_valid), 64'(1));
    chk("rd_t2_pc", 64'(s_pc), 64'(32'h40));
    chk("rd_t2_instr", 64'(s_instr), 64'(32'h1040));
    cyc();
    chk("rd_t3_pc", 64'(s_pc), 64'(32'h41));

    // Wrap from DEPTH-1 to 0, redirecting mid-stream with a read in flight
    redirect_valid = 1'b1; redirect_pc = AW'(DEPTH - 3);
    cyc();
    redirect_valid = 1'b0;
    run(2);
    chk("wrap_t2_pc", 64'(s_pc), 64'(DEPTH - 3));
    run(2);
    chk("wrap_last_pc", 64'(s_pc), 64'(DEPTH - 1));
    chk("wrap_last_instr", 64'(s_instr), 64'(32'h17ff));
    cyc();
    chk("wrap_zero_pc", 64'(s_pc), 64'(0));
    chk("wrap_zero_instr", 64'(s_instr), 64'(32'h1000));

    // fetch_en dropped for 5 cycles
    fetch_en = 1'b0;
    cyc();
    cyc();
    chk("fe_inflight_valid", 64'(s_valid), 64'(1));
    p = s_pc;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fe_drained_valid", 64'(s_valid), 64'(0));
    end
    fetch_en = 1'b1;
    cyc();
    chk("fe_resume_en", 64'(s_en), 64'(1));
    chk("fe_resume_addr", 64'(s_addr), 64'(p + 1));
    run(4);

    // Reset pulse with a full buffer
    out_ready = 1'b0;
    run(4);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_valid", 64'(s_valid), 64'(0));
    chk("rst_pc", 64'(s_pc), 64'(0));
    chk("rst_instr", 64'(s_instr), 64'(0));
    chk("rst_restart_addr", 64'(s_addr), 64'(0));
    out_ready = 1'b1;
    run(4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      fetch_en       = ($urandom_range(0, 99) < 85);
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH - 3, DEPTH - 1))
                                                   : AW'($urandom_range(0, DEPTH - 1));
      rst_n          = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n = 1'b1; redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    run(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
